gcbp_multi: RTL
===============

Name: gcbp_multi

Overview:
- Parametrised successor to the gray-code bit-plane (GCBP) generator in the stabilisation pipeline.
- Input is a luma pixel stream. Each pixel is Gray-coded, and one runtime-selectable bit plane is extracted from it.
- Plane bits are packed into BANK_W-bit words and written into a NUM_BANKS-wide BRAM array, one bank per horizontal sub-image.
- The block also rotates NUM_SLOTS frame buffers (next/curr/prev) for the downstream motion estimator.

Parameters:
- PIX_W, 8, luma pixel width.
- NUM_BANKS, 16, number of BRAM banks, which is also the number of horizontal sub-images.
- BANK_W, 8, data width of each bank; plane bits packed per write.
- SUB_W, 40, pixels per sub-image per line; must be a multiple of BANK_W.
- ROW_START, 16, first captured line (compared with i_line_cnt).
- ROWS, 32, number of captured lines per frame.
- NUM_SLOTS, 3, number of frame buffers per bank (3..4).
- ADDR_W, 9, bank address width; NUM_SLOTS*ROWS*SUB_W/BANK_W must be ≤ 2^ADDR_W.
- LINE_W, 10, line counter width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_luma_data  in  PIX_W  pixel value.
- i_luma_data_valid  in  1  pixel qualifier, one pixel per asserted cycle.
- i_line_cnt  in  LINE_W  current line number; any change starts a new line.
- i_field_0  in  1  field flag; a rising edge marks frame start.
- i_plane_sel  in  clog2(PIX_W)  Gray bit plane to extract; latched at frame start.
- o_bram_array_write_addr  out  ADDR_W  shared write address.
- o_bram_array_write_data  out  NUM_BANKS*BANK_W  bank b occupies lane [b*BANK_W +: BANK_W].
- o_bram_array_write_enable  out  NUM_BANKS  one-hot bank write strobe.
- o_next_frame_loc  out  2  slot being written.
- o_curr_frame_loc  out  2  most recently completed slot.
- o_prev_frame_loc  out  2  slot before curr.
- o_frame_done  out  1  one-cycle pulse on the final write of a frame.

Behaviour:
- Reset values: all outputs 0, except curr=0, next=1, prev=NUM_SLOTS-1. Reset also clears:
  - column counter and shift register;
  - plane register (reset to 0);
  - the stored edge/line history.
- Reset applies at any point mid-frame. The first frame after reset starts only at the next i_field_0 rising edge; no writes occur before it.
- Frame start (registered i_field_0 was 0, now 1). In that cycle:
  - next, curr and prev each advance +1 mod NUM_SLOTS;
  - i_plane_sel is latched;
  - column counter, word count and shift register are cleared.
  - A valid pixel in the same cycle is column 0 of the new frame.
- New line (i_line_cnt differs from its registered value): column counter and shift register are cleared. An incomplete partial word is discarded and never written. A valid pixel in the same cycle is column 0.
- Pixel acceptance: only when valid, ROW_START ≤ i_line_cnt < ROW_START+ROWS, and column < NUM_BANKS*SUB_W. The column increments on every valid pixel, whether accepted or not. Pixels outside the window are dropped.
- Gray code: g = p ^ (p >> 1). The plane bit is g[plane_reg].
- Packing: bits shift in MSB-first; the first pixel of a word ends in bit BANK_W-1.
- Bank selection: bank = column / SUB_W. Word index w = (column mod SUB_W) / BANK_W.
- Write timing: the write fires one cycle after the valid of the BANK_W-th bit of a word (a single registered stage).
  - write_enable = one-hot(bank).
  - Data for the bank is placed in its lane; all other lanes are 0.
  - addr = next*ROWS*WPR + (i_line_cnt-ROW_START)*WPR + w, where WPR = SUB_W/BANK_W.
  - Strobes last one cycle; enable is 0 otherwise.
- o_frame_done: pulses together with the write of row ROWS-1, bank NUM_BANKS-1, word WPR-1.
- Slot wrap-around is modulo NUM_SLOTS, not 2^2. The three location outputs are always distinct.
- Widths: all address arithmetic is done in ADDR_W+2 bits, then truncated. Parameter legality is checked at elaboration.

Decomposition:
- Shared package gcbp_pkg holds:
  - gray-code function;
  - slot-increment function (mod NUM_SLOTS);
  - localparams WPR, SLOT_DEPTH, COL_W and PLANE_W.
- One natural sub-module, gcbp_slot_rot: frame-edge detector plus next/curr/prev rotation and o_frame_done bookkeeping. The packer and address generator stay in the top level.

Test Plan:
- Reset, then a field rising edge → next=2, curr=1, prev=0. A second edge gives next=0, curr=2, prev=1; a third restores next=1, curr=0, prev=2.
- i_luma_data=8'h10 (Gray 8'h18), plane_sel=4, line 16, 8 valid pixels → one write:
  - enable=16'h0001, addr=WPR*ROWS*1=160, lane0=8'hFF;
  - the write occurs 1 cycle after the 8th valid.
- Same stream with plane_sel=2, full line 16 → 80 writes:
  - all data 0, enables walk through bank 0..15 with 5 words each;
  - last write has enable=16'h8000, addr=164.
- Line change after 5 pixels of a word → no write for the partial word, and the next line restarts at w=0.
- Lines 15 and 48 driven with valid pixels → no write enables asserted.
- Full frame of rows 16..47 → exactly one o_frame_done pulse, coincident with the write to bank 15, addr=next*160+159.
- Assert i_reset mid-line → all enables 0 the next cycle and locations back to next=1, curr=0, prev=2; no writes until the next field edge.

Source files
------------

// File: rtl/gcbp_pkg.sv
// Shared definitions for the gray-code bit-plane generator: default geometry,
// derived sizes, and the gray-code / slot-rotation helpers.
package gcbp_pkg;

    localparam int PIX_W_DEF     = 8;
    localparam int NUM_BANKS_DEF = 16;
    localparam int BANK_W_DEF    = 8;
    localparam int SUB_W_DEF     = 40;
    localparam int ROWS_DEF      = 32;

    localparam int WPR        = SUB_W_DEF / BANK_W_DEF;
    localparam int SLOT_DEPTH = ROWS_DEF * WPR;
    localparam int COL_W      = $clog2(NUM_BANKS_DEF * SUB_W_DEF + 1);
    localparam int PLANE_W    = $clog2(PIX_W_DEF);

    function automatic logic [31:0] gray_code(input logic [31:0] p);
        return p ^ (p >> 1);
    endfunction

    // Wraps at num_slots rather than at the 2-bit width.
    function automatic logic [1:0] slot_inc(input logic [1:0] s, input int num_slots);
        return (int'(s) == num_slots - 1) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/gcbp_slot_rot.sv
// Frame-edge detector, next/curr/prev frame-slot rotation and the frame-done pulse
// that is aligned with the registered bank write.
module gcbp_slot_rot
    import gcbp_pkg::*;
#(
    parameter int NUM_SLOTS = 3
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       field_0,
    input  logic       last_word,
    output logic       frame_start,
    output logic       frame_active,
    output logic [1:0] next_loc,
    output logic [1:0] curr_loc,
    output logic [1:0] prev_loc,
    output logic       frame_done
);

    logic field_reg;
    logic active_reg;

    assign frame_start  = field_0 && !field_reg;
    // Nothing is captured after reset until the first frame edge has been seen.
    assign frame_active = active_reg || frame_start;

    always_ff @(posedge clk) begin
        if (srst) begin
            field_reg  <= 1'b0;
            active_reg <= 1'b0;
            next_loc   <= 2'd1;
            curr_loc   <= 2'd0;
            prev_loc   <= 2'(NUM_SLOTS - 1);
            frame_done <= 1'b0;
        end else begin
            field_reg  <= field_0;
            frame_done <= last_word;
            if (frame_start) begin
                active_reg <= 1'b1;
                next_loc   <= slot_inc(next_loc, NUM_SLOTS);
                curr_loc   <= slot_inc(curr_loc, NUM_SLOTS);
                prev_loc   <= slot_inc(prev_loc, NUM_SLOTS);
            end
        end
    end

endmodule

// File: rtl/gcbp_multi.sv
// Gray-code bit-plane extractor: packs one plane of the luma stream into
// BANK_W-bit words spread over NUM_BANKS BRAM banks, one bank per sub-image.
module gcbp_multi
    import gcbp_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int NUM_BANKS = 16,
    parameter int BANK_W    = 8,
    parameter int SUB_W     = 40,
    parameter int ROW_START = 16,
    parameter int ROWS      = 32,
    parameter int NUM_SLOTS = 3,
    parameter int ADDR_W    = 9,
    parameter int LINE_W    = 10
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [PIX_W-1:0]              i_luma_data,
    input  logic                          i_luma_data_valid,
    input  logic [LINE_W-1:0]             i_line_cnt,
    input  logic                          i_field_0,
    input  logic [$clog2(PIX_W)-1:0]      i_plane_sel,
    output logic [ADDR_W-1:0]             o_bram_array_write_addr,
    output logic [NUM_BANKS*BANK_W-1:0]   o_bram_array_write_data,
    output logic [NUM_BANKS-1:0]          o_bram_array_write_enable,
    output logic [1:0]                    o_next_frame_loc,
    output logic [1:0]                    o_curr_frame_loc,
    output logic [1:0]                    o_prev_frame_loc,
    output logic                          o_frame_done
);

    localparam int LINE_WORDS = SUB_W / BANK_W;
    localparam int SLOT_WORDS = ROWS * LINE_WORDS;
    localparam int LINE_PIX   = NUM_BANKS * SUB_W;
    localparam int COL_BITS   = $clog2(LINE_PIX + 1);
    localparam int SEL_W      = $clog2(PIX_W);
    localparam int AW2        = ADDR_W + 2;

    generate
        if (SUB_W % BANK_W != 0) begin : g_bad_sub_w
            $error("SUB_W must be a multiple of BANK_W");
        end
        if (BANK_W < 2) begin : g_bad_bank_w
            $error("BANK_W must be at least 2");
        end
        if (NUM_SLOTS < 3 || NUM_SLOTS > 4) begin : g_bad_slots
            $error("NUM_SLOTS must be 3 or 4");
        end
        if (NUM_SLOTS * SLOT_WORDS > (1 << ADDR_W)) begin : g_bad_addr_w
            $error("frame slots do not fit in ADDR_W address bits");
        end
        if (PIX_W > 32 || ROW_START + ROWS > (1 << LINE_W)) begin : g_bad_widths
            $error("PIX_W or LINE_W out of range");
        end
    endgenerate

    logic                        frame_start;
    logic                        frame_active;
    logic                        new_line;
    logic                        in_rows;
    logic                        accept;
    logic                        word_done;
    logic                        last_word;
    logic                        plane_bit;
    logic [LINE_W-1:0]           line_reg;
    logic [COL_BITS-1:0]         col_reg;
    logic [COL_BITS-1:0]         col_cur;
    logic [COL_BITS-1:0]         col_next;
    logic [COL_BITS-1:0]         bank_num;
    logic [BANK_W-1:0]           shift_reg;
    logic [BANK_W-1:0]           shift_cur;
    logic [BANK_W-1:0]           shift_next;
    logic [SEL_W-1:0]            plane_reg;
    logic [SEL_W-1:0]            plane_cur;
    logic [PIX_W-1:0]            gray;
    logic [AW2-1:0]              word_idx;
    logic [AW2-1:0]              row_idx;
    logic [ADDR_W-1:0]           addr_next;
    logic [NUM_BANKS-1:0]        en_next;
    logic [NUM_BANKS*BANK_W-1:0] data_next;

    gcbp_slot_rot #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_rot (
        .clk          (i_clk),
        .srst         (i_reset),
        .field_0      (i_field_0),
        .last_word    (last_word),
        .frame_start  (frame_start),
        .frame_active (frame_active),
        .next_loc     (o_next_frame_loc),
        .curr_loc     (o_curr_frame_loc),
        .prev_loc     (o_prev_frame_loc),
        .frame_done   (o_frame_done)
    );

    // A frame edge or line change makes this cycle's pixel column 0 and drops any partial word.
    assign new_line  = (i_line_cnt != line_reg);
    assign col_cur   = (frame_start || new_line) ? '0 : col_reg;
    assign shift_cur = (frame_start || new_line) ? '0 : shift_reg;
    assign plane_cur = frame_start ? i_plane_sel : plane_reg;

    assign in_rows   = (int'(i_line_cnt) >= ROW_START) && (int'(i_line_cnt) < ROW_START + ROWS);
    assign accept    = frame_active && i_luma_data_valid && in_rows &&
                       (col_cur < COL_BITS'(LINE_PIX));
    assign gray      = PIX_W'(gray_code(32'(i_luma_data)));
    assign plane_bit = gray[plane_cur];

    assign shift_next = accept ? BANK_W'({shift_cur, plane_bit}) : shift_cur;
    assign col_next   = (i_luma_data_valid && col_cur != COL_BITS'(LINE_PIX)) ?
                        col_cur + 1'b1 : col_cur;

    assign word_done = accept && ((col_cur % COL_BITS'(BANK_W)) == COL_BITS'(BANK_W - 1));
    assign last_word = word_done && (int'(i_line_cnt) == ROW_START + ROWS - 1) &&
                       (col_cur == COL_BITS'(LINE_PIX - 1));

    assign bank_num  = col_cur / COL_BITS'(SUB_W);
    assign word_idx  = AW2'((col_cur % COL_BITS'(SUB_W)) / COL_BITS'(BANK_W));
    assign row_idx   = AW2'(i_line_cnt) - AW2'(ROW_START);
    assign addr_next = ADDR_W'(AW2'(o_next_frame_loc) * AW2'(SLOT_WORDS) +
                               row_idx * AW2'(LINE_WORDS) + word_idx);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_lane
            assign en_next[gi] = word_done && (bank_num == COL_BITS'(gi));
            assign data_next[gi*BANK_W +: BANK_W] = en_next[gi] ? shift_next : '0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            line_reg                  <= '0;
            col_reg                   <= '0;
            shift_reg                 <= '0;
            plane_reg                 <= '0;
            o_bram_array_write_addr   <= '0;
            o_bram_array_write_data   <= '0;
            o_bram_array_write_enable <= '0;
        end else begin
            line_reg                  <= i_line_cnt;
            col_reg                   <= col_next;
            shift_reg                 <= shift_next;
            plane_reg                 <= plane_cur;
            o_bram_array_write_data   <= data_next;
            o_bram_array_write_enable <= en_next;
            if (word_done) begin
                o_bram_array_write_addr <= addr_next;
            end
        end
    end

endmodule
